// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   STARVE_LIMIT_DEFAULT : denied DMA cycles tolerated before DMA is forced a grant
//   rd_owner_e           : which requester owns the read response in flight
package dmem_arbiter_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_PIPE = 2'd1,
        RD_DMA  = 2'd2
    } rd_owner_e;

endpackage

// File: rtl/dmem_arbiter_starve.sv
// Starvation counter for the DMA requester.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : DMA is requesting this cycle
//   gnt        : DMA was granted this cycle
//   limit_hit  : DMA has been denied LIMIT consecutive requesting cycles
module starve_counter #(
    parameter int unsigned LIMIT = dmem_arbiter_pkg::STARVE_LIMIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic limit_hit
);

    localparam int unsigned CW = $clog2(LIMIT + 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign limit_hit = (cnt_q == CW'(LIMIT));

    // Any gap in the request or any grant restarts the count; otherwise
    // count denials and saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!req || gnt) begin
            cnt_d = '0;
        end else if (!limit_hit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline MEM stage and a
// DMA/loader. The memory itself lives outside; this block only muxes the
// request onto it and tags the one-cycle-later read response.
//   p_req/p_we/p_addr/p_wdata : pipeline request
//   p_stall, p_rvalid         : pipeline hold and load-data valid
//   d_req/d_we/d_addr/d_wdata : DMA request
//   d_gnt, d_rvalid           : DMA accept and read-data valid
//   rdata                     : shared read data (= m_rdata)
//   m_addr/m_wdata/m_wen      : memory request, m_rdata arrives next cycle
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned AW           = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [31:0]   p_wdata,
    output logic          p_stall,
    output logic          p_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   rdata,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    output logic          m_wen,
    input  logic [31:0]   m_rdata
);

    rd_owner_e rd_owner_q;
    rd_owner_e rd_owner_d;
    logic      p_gnt;
    logic      limit_hit;

    starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (d_req),
        .gnt      (d_gnt),
        .limit_hit(limit_hit)
    );

    // Pipeline has priority unless DMA has hit its starvation limit.
    // Grants are masked during reset so nothing reaches the memory.
    always_comb begin
        p_gnt = rst_n & p_req & ~(d_req & limit_hit);
        d_gnt = rst_n & d_req & ~p_gnt;
    end

    assign p_stall = p_req & ~p_gnt & rst_n;

    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_wen   = 1'b0;
        if (p_gnt) begin
            m_addr  = p_addr;
            m_wdata = p_wdata;
            m_wen   = p_we;
        end else if (d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_wen   = d_we;
        end
    end

    always_comb begin
        rd_owner_d = RD_NONE;
        if (p_gnt && !p_we) begin
            rd_owner_d = RD_PIPE;
        end else if (d_gnt && !d_we) begin
            rd_owner_d = RD_DMA;
        end
    end

    // Asynchronous clear drops any in-flight response; it is never replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q <= RD_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    assign p_rvalid = (rd_owner_q == RD_PIPE);
    assign d_rvalid = (rd_owner_q == RD_DMA);
    assign rdata    = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk;
    logic        rst_n;
    logic        p_req, p_we, d_req, d_we;
    logic [31:0] p_addr, p_wdata, d_addr, d_wdata;
    logic        p_stall, p_rvalid, d_gnt, d_rvalid, m_wen;
    logic [31:0] rdata, m_addr, m_wdata, m_rdata;

    int total  = 0;
    int passed = 0;

    dmem_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .AW          (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .p_req   (p_req),
        .p_we    (p_we),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_stall (p_stall),
        .p_rvalid(p_rvalid),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .rdata   (rdata),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wen   (m_wen),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External data memory: synchronous write, one-cycle read latency.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (m_wen) mem[m_addr[7:0]] <= m_wdata;
        m_rdata <= mem[m_addr[7:0]];
    end

    // Behavioural model: counter of denied DMA cycles, owner of the
    // outstanding read, and a shadow copy of memory contents.
    int          denied = 0;
    int          pend   = 0;          // 0 none, 1 pipeline, 2 DMA
    logic [31:0] pend_data = '0;
    logic [31:0] shadow [256];

    function automatic logic exp_pg();
        return rst_n && p_req && !(d_req && denied == int'(LIMIT));
    endfunction

    function automatic logic exp_dg();
        return rst_n && d_req && !exp_pg();
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) passed = passed + 1;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            denied <= 0;
            pend   <= 0;
        end else begin
            logic        pg, dg, we;
            logic [31:0] a, wd;
            pg = exp_pg();
            dg = exp_dg();
            we = pg ? p_we : d_we;
            a  = pg ? p_addr : d_addr;
            wd = pg ? p_wdata : d_wdata;
            pend      <= ((pg || dg) && !we) ? (pg ? 1 : 2) : 0;
            pend_data <= shadow[a[7:0]];
            if ((pg || dg) && we) shadow[a[7:0]] <= wd;
            if (d_req && !dg) denied <= (denied < int'(LIMIT)) ? denied + 1 : denied;
            else              denied <= 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic pg, dg, we_x;
        logic [31:0] a, wd;
        pg   = exp_pg();
        dg   = exp_dg();
        we_x = (pg && p_we) || (dg && d_we);
        a    = pg ? p_addr : (dg ? d_addr : 32'h0);
        wd   = pg ? p_wdata : (dg ? d_wdata : 32'h0);
        check("d_gnt",    {31'b0, d_gnt},    {31'b0, dg});
        check("p_stall",  {31'b0, p_stall},  {31'b0, rst_n && p_req && !pg});
        check("m_wen",    {31'b0, m_wen},    {31'b0, we_x});
        check("m_addr",   m_addr,            a);
        check("m_wdata",  m_wdata,           wd);
        check("p_rvalid", {31'b0, p_rvalid}, {31'b0, rst_n && pend == 1});
        check("d_rvalid", {31'b0, d_rvalid}, {31'b0, rst_n && pend == 2});
        if (rst_n && pend != 0) check("rdata", rdata, pend_data);
    end

    task automatic drive(input logic pr, input logic pw, input logic [31:0] pa, input logic [31:0] pd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] dpat;
        logic [5:0] spat;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        rst_n = 1'b0;
        idle();

        // Reset: requests are ignored, memory port idle.
        drive(1, 1, 32'h10, 32'hAAAA5555, 1, 1, 32'h14, 32'h1);
        check("rst_m_wen",  {31'b0, m_wen},   32'h0);
        check("rst_d_gnt",  {31'b0, d_gnt},   32'h0);
        check("rst_p_stall",{31'b0, p_stall}, 32'h0);
        check("rst_m_addr", m_addr,           32'h0);
        step(); step();
        rst_n = 1'b1;
        idle();
        step();

        // Pipeline store then load of 0x10.
        drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
        check("st_m_wen",   {31'b0, m_wen},   32'h1);
        check("st_p_stall", {31'b0, p_stall}, 32'h0);
        step();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        step();
        idle();
        check("ld_p_rvalid", {31'b0, p_rvalid}, 32'h1);
        check("ld_rdata",    rdata,             32'hDEADBEEF);
        step();

        // Both requesting for 6 cycles: DMA forced in cycle 4 only.
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h50, 0, 1, 0, 32'h60, 0);
            dpat[i] = d_gnt;
            spat[i] = p_stall;
            step();
        end
        check("starve_dgnt",  {26'b0, dpat}, 32'h10);
        check("starve_stall", {26'b0, spat}, 32'h10);
        idle();
        step();

        // DMA-only requester is granted; DMA read response tagged correctly
        // while a pipeline write occupies the response cycle.
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
        check("dwr_d_gnt", {31'b0, d_gnt}, 32'h1);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
        step();
        drive(1, 1, 32'h70, 32'h0BADF00D, 0, 0, 0, 0);
        check("drd_d_rvalid", {31'b0, d_rvalid}, 32'h1);
        check("drd_p_rvalid", {31'b0, p_rvalid}, 32'h0);
        check("drd_rdata",    rdata,             32'h12345678);
        check("drd_m_wen",    {31'b0, m_wen},    32'h1);
        step();

        // Reset mid-read drops the response; normal arbitration after release.
        drive(1, 0, 32'h30, 0, 0, 0, 0, 0);
        step();
        rst_n = 1'b0;
        #2;
        check("rstrd_p_rvalid", {31'b0, p_rvalid}, 32'h0);
        idle();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h30, 0, 1, 0, 32'h34, 0);
            if (i == 0) check("post_rst_p_rvalid", {31'b0, p_rvalid}, 32'h0);
            dpat[i] = d_gnt;
            step();
        end
        check("post_rst_dgnt", {26'b0, dpat}, 32'h10);
        idle();
        step();

        // Read then write of 0x40 in consecutive cycles.
        drive(1, 1, 32'h40, 32'h1, 0, 0, 0, 0);
        step();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
        step();
        drive(1, 1, 32'h40, 32'h2, 0, 0, 0, 0);
        check("rw_old_rdata", rdata, 32'h1);
        step();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
        step();
        idle();
        check("rw_new_rdata", rdata, 32'h2);
        step();

        // DMA drops after 3 denials: counter restarts, forced grant only
        // after 4 fresh denials.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h80, 0, 1, 0, 32'h84, 0);
            step();
        end
        drive(1, 0, 32'h80, 0, 0, 0, 0, 0);
        check("drop_p_stall", {31'b0, p_stall}, 32'h0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 32'h80, 0, 1, 0, 32'h84, 0);
            dpat[i] = d_gnt;
            step();
        end
        check("restart_dgnt", {26'b0, dpat}, 32'h10);

        // p_req low never stalls.
        drive(0, 0, 0, 0, 1, 0, 32'h88, 0);
        check("noreq_p_stall", {31'b0, p_stall}, 32'h0);
        step();
        idle();
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
